// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate execute stage.
package mac_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    MUL   = 3'd2,
    ADD   = 3'd3,
    WB    = 3'd4
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mac_execute_multiplier.sv
// Iterative unsigned shift-add multiplier: one multiplier bit retired per step.
module shift_add_multiplier
  import mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done_mul
);

  localparam int CW = cnt_w(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  always_ff @(posedge clk) begin
    if (RESET) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (step && cnt != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  assign product  = acc;
  // Asserted during the final step, so the FSM leaves MUL exactly as cnt hits 0.
  assign done_mul = (cnt == CW'(1));

endmodule

// File: rtl/mac_execute.sv
// Execute stage: fetches three operands, computes A*B+C, writes the result back.
module mac_execute
  import mac_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int FETCH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              start,
  output logic              ready,
  input  logic [ADDR_W-1:0] a_sel,
  input  logic [ADDR_W-1:0] b_sel,
  input  logic [ADDR_W-1:0] c_sel,
  input  logic [ADDR_W-1:0] dst_sel,
  output logic [ADDR_W-1:0] read_addr_A,
  output logic [ADDR_W-1:0] read_addr_B,
  output logic [ADDR_W-1:0] read_addr_C,
  input  logic [WIDTH-1:0]  read_data_A,
  input  logic [WIDTH-1:0]  read_data_B,
  input  logic [WIDTH-1:0]  read_data_C,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [WIDTH-1:0]  write_data,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int FW = (FETCH_CYCLES > 1) ? $clog2(FETCH_CYCLES) : 1;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]  a_q, b_q, c_q, dst_q;
  logic [FW-1:0]      fcnt;
  logic [WIDTH-1:0]   opc_q;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH:0]   sum;
  logic               last_fetch, load, step, done_mul, accept;

  assign accept     = (state_q == IDLE) && start;
  assign last_fetch = (fcnt == FW'(FETCH_CYCLES - 1));
  assign load       = (state_q == FETCH) && last_fetch;
  assign step       = (state_q == MUL);
  assign sum        = {1'b0, product} + {{(WIDTH+1){1'b0}}, opc_q};

  shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .RESET    (RESET),
    .load     (load),
    .step     (step),
    .a        (read_data_A),
    .b        (read_data_B),
    .product  (product),
    .done_mul (done_mul)
  );

  always_ff @(posedge clk) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (last_fetch) state_d = MUL;
      MUL:     if (done_mul) state_d = ADD;
      ADD:     state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      dst_q      <= '0;
      fcnt       <= '0;
      opc_q      <= '0;
      write_addr <= '0;
      write_data <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        a_q      <= a_sel;
        b_q      <= b_sel;
        c_q      <= c_sel;
        dst_q    <= dst_sel;
        fcnt     <= '0;
        overflow <= 1'b0;
      end
      if (state_q == FETCH) begin
        fcnt <= fcnt + FW'(1);
        if (last_fetch) opc_q <= read_data_C;
      end
      // Result registers load at the end of ADD so they are visible during WB.
      if (state_q == ADD) begin
        write_addr <= dst_q;
        write_data <= sum[WIDTH-1:0];
        overflow   <= |sum[2*WIDTH:WIDTH];
      end
    end
  end

  assign read_addr_A  = a_q;
  assign read_addr_B  = b_q;
  assign read_addr_C  = c_q;
  assign ready        = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign write_enable = (state_q == WB);
  assign done         = (state_q == WB);

endmodule

// File: tb/tb_mac_execute.sv
// Directed bench for mac_execute with a behavioural 8x16 register file.
module tb_mac_execute;

  logic        clk = 1'b0;
  logic        RESET;
  logic        start;
  logic        ready;
  logic [2:0]  a_sel, b_sel, c_sel, dst_sel;
  logic [2:0]  read_addr_A, read_addr_B, read_addr_C;
  logic [15:0] read_data_A, read_data_B, read_data_C;
  logic        write_enable;
  logic [2:0]  write_addr;
  logic [15:0] write_data;
  logic        busy, done, overflow;

  logic [15:0] rf [8];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_execute dut (
    .clk(clk), .RESET(RESET), .start(start), .ready(ready),
    .a_sel(a_sel), .b_sel(b_sel), .c_sel(c_sel), .dst_sel(dst_sel),
    .read_addr_A(read_addr_A), .read_addr_B(read_addr_B), .read_addr_C(read_addr_C),
    .read_data_A(read_data_A), .read_data_B(read_data_B), .read_data_C(read_data_C),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .busy(busy), .done(done), .overflow(overflow)
  );

  assign read_data_A = rf[read_addr_A];
  assign read_data_B = rf[read_addr_B];
  assign read_data_C = rf[read_addr_C];

  always @(posedge clk) if (write_enable) rf[write_addr] <= write_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command in the current (ready) cycle and checks it through T+20.
  // inj_at > 0 pulses a second start with dst=7 in cycle T+inj_at.
  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                        input logic [2:0] d, input logic [15:0] exp_data,
                        input logic exp_ovf, input int inj_at, input string name);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL %s accept: ready=%b want 1", name, ready); end
    a_sel = a; b_sel = b; c_sel = c; dst_sel = d; start = 1'b1;
    tick();  // cycle T+1
    start = 1'b0;
    a_sel = ~a; b_sel = ~b; c_sel = ~c; dst_sel = ~d;
    checks++;
    if ({read_addr_A, read_addr_B, read_addr_C} !== {a, b, c}) begin
      errors++;
      $display("FAIL %s read_addr: got %0d/%0d/%0d want %0d/%0d/%0d", name,
               read_addr_A, read_addr_B, read_addr_C, a, b, c);
    end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL %s ovf_clear: got %b want 0", name, overflow); end
    for (int k = 1; k <= 19; k++) begin
      if (k > 1) tick();
      if (inj_at > 0 && k == inj_at) begin start = 1'b1; dst_sel = 3'd7; end
      else if (inj_at > 0 && k == inj_at + 1) start = 1'b0;
      checks++;
      if (ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy T+%0d: ready=%b busy=%b want 0/1", name, k, ready, busy);
      end
      checks++;
      if (write_enable !== (k == 19) || done !== (k == 19)) begin
        errors++;
        $display("FAIL %s we T+%0d: we=%b done=%b want %b", name, k, write_enable, done, k == 19);
      end
    end
    start = 1'b0;
    checks++;
    if (write_addr !== d || write_data !== exp_data || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL %s result: addr=%0d data=%h ovf=%b want addr=%0d data=%h ovf=%b",
               name, write_addr, write_data, overflow, d, exp_data, exp_ovf);
    end
    tick();  // cycle T+20
    checks++;
    if (ready !== 1'b1 || write_enable !== 1'b0 || overflow !== exp_ovf || rf[d] !== exp_data) begin
      errors++;
      $display("FAIL %s after_wb: ready=%b we=%b ovf=%b rf=%h want 1/0/%b/%h",
               name, ready, write_enable, overflow, rf[d], exp_ovf, exp_data);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; start = 1'b0;
    a_sel = '0; b_sel = '0; c_sel = '0; dst_sel = '0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    tick(); tick();
    RESET = 1'b0;
    checks++;
    if ({ready, busy, done, write_enable, overflow} !== 5'b10000 ||
        write_addr !== 3'd0 || write_data !== 16'h0 ||
        {read_addr_A, read_addr_B, read_addr_C} !== 9'h0) begin
      errors++;
      $display("FAIL reset: rdy/bsy/dn/we/ov=%b wa=%0d wd=%h ra=%h want 10000/0/0/0",
               {ready, busy, done, write_enable, overflow}, write_addr, write_data,
               {read_addr_A, read_addr_B, read_addr_C});
    end
  endtask

  task automatic test_basic();
    rf[0] = 16'd3; rf[1] = 16'd4; rf[2] = 16'd5;
    run_op(3'd0, 3'd1, 3'd2, 3'd6, 16'd17, 1'b0, 0, "basic");
  endtask

  task automatic test_overflow_wrap();
    rf[0] = 16'hFFFF; rf[1] = 16'hFFFF; rf[2] = 16'h0001;
    run_op(3'd0, 3'd1, 3'd2, 3'd6, 16'h0002, 1'b1, 0, "ovf_wrap");
  endtask

  task automatic test_overflow_add();
    rf[0] = 16'h0001; rf[1] = 16'h0001; rf[2] = 16'hFFFF;
    run_op(3'd0, 3'd1, 3'd2, 3'd6, 16'h0000, 1'b1, 0, "ovf_add");
  endtask

  task automatic test_back_to_back();
    rf[0] = 16'd3; rf[1] = 16'd4; rf[2] = 16'd5; rf[7] = 16'h1234;
    run_op(3'd0, 3'd1, 3'd2, 3'd6, 16'd17, 1'b0, 5, "busy_ignore");
    checks++;
    if (rf[7] !== 16'h1234) begin errors++; $display("FAIL ignored_start: rf7=%h want 1234", rf[7]); end
    rf[0] = 16'd10; rf[1] = 16'd20;
    run_op(3'd0, 3'd1, 3'd2, 3'd5, 16'd205, 1'b0, 0, "back_to_back");
  endtask

  task automatic test_reset_mid_mul();
    rf[0] = 16'hFFFF; rf[1] = 16'hFFFF; rf[2] = 16'h0001; rf[4] = 16'h5555;
    a_sel = 3'd0; b_sel = 3'd1; c_sel = 3'd2; dst_sel = 3'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    RESET = 1'b1;
    tick();  // cycle T+11
    RESET = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b busy=%b ovf=%b want 1/0/0", ready, busy, overflow);
    end
    for (int k = 11; k <= 30; k++) begin
      checks++;
      if (write_enable !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_we T+%0d: we=%b done=%b want 0", k, write_enable, done);
      end
      tick();
    end
    checks++;
    if (rf[4] !== 16'h5555) begin errors++; $display("FAIL reset_mid_rf: rf4=%h want 5555", rf[4]); end
  endtask

  task automatic test_in_place();
    rf[3] = 16'd2;
    run_op(3'd3, 3'd3, 3'd3, 3'd3, 16'd6, 1'b0, 0, "in_place1");
    run_op(3'd3, 3'd3, 3'd3, 3'd3, 16'd42, 1'b0, 0, "in_place2");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow_wrap();
    test_overflow_add();
    test_back_to_back();
    test_reset_mid_mul();
    test_in_place();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_execute.md
Name: mac_execute

Overview:
- Multi-cycle execute stage that sits directly downstream of the 8x16 three-read-port register file and also drives its write port.
- On an accepted command it drives read_addr_A/B/C and captures the three operands.
- It computes D = A*B + C with an iterative shift-add multiplier, then writes D back to the register file for one cycle.
- Reports completion and overflow to the sequencer.

Parameters:
- WIDTH, 16, data width of operands and result.
- ADDR_W, 3, register address width (8 registers).
- FETCH_CYCLES, 1, cycles read addresses are held before operand capture; 1 means combinational register-file read, 2 means registered read.

Ports:
- clk  in  1  single clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  command valid; accepted only when ready=1.
- ready  out  1  high in IDLE only.
- a_sel / b_sel / c_sel  in  ADDR_W each  operand register addresses.
- dst_sel  in  ADDR_W  destination register address.
- read_addr_A / read_addr_B / read_addr_C  out  ADDR_W each  to register file read ports.
- read_data_A / read_data_B / read_data_C  in  WIDTH each  from register file.
- write_enable  out  1  register file write strobe.
- write_addr  out  ADDR_W  register file write address.
- write_data  out  WIDTH  register file write data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse, coincident with write_enable.
- overflow  out  1  held from writeback until the next accepted start; 1 if the true A*B+C does not fit in WIDTH bits.

Behaviour:
- Interface: one clock, clk; reset RESET is synchronous and active-high.
- Reset values:
  - ready=1; busy=0; done=0; write_enable=0; overflow=0.
  - write_addr=0; write_data=0; read_addr_A/B/C=0.
  - State = IDLE; all internal accumulators cleared.
- States: IDLE, FETCH, MUL, ADD, WB.
- IDLE:
  - ready=1.
  - If start=1 at edge T: latch a/b/c/dst_sel, clear overflow, go to FETCH.
- FETCH:
  - Occupies cycles T+1 .. T+FETCH_CYCLES.
  - read_addr_A/B/C = latched selects, held stable throughout.
  - On the last FETCH cycle, capture read_data_A/B/C into opA/opB/opC.
  - Clear the 2*WIDTH-bit product accumulator; set the bit counter to WIDTH.
  - Go to MUL.
- MUL:
  - Exactly WIDTH cycles.
  - Each cycle: if the LSB of the multiplier is 1, add the multiplicand, shifted to the current bit position, into the accumulator; shift the multiplier right by 1; decrement the counter.
  - When the counter reaches 0, go to ADD.
  - All arithmetic is unsigned.
- ADD:
  - 1 cycle: sum = product + zero-extended opC, computed at 2*WIDTH+1 bits.
  - overflow_next = OR of sum bits above WIDTH-1.
  - Go to WB.
- WB:
  - 1 cycle: write_enable=1, done=1, write_addr=latched dst_sel, write_data=sum[WIDTH-1:0], overflow updated.
  - Go to IDLE.
- Latency:
  - write_enable is high in cycle T+FETCH_CYCLES+WIDTH+2 (T+19 with defaults).
  - ready returns high the following cycle.
- Outside WB, write_enable=0 and done=0. write_addr and write_data hold their last values.
- start while busy is ignored, not queued. Back-to-back: the earliest next accept is the cycle after WB.
- dst_sel equal to any source selector is legal, because operands are captured before writeback.
- RESET in any state: next cycle is IDLE, no write is issued, and an in-flight command is discarded. RESET has priority over start.
- Input selects may change after acceptance without effect.

Decomposition:
- Shared package mac_pkg:
  - State encoding constants (IDLE=0, FETCH=1, MUL=2, ADD=3, WB=4).
  - Default WIDTH=16 and ADDR_W=3.
  - Counter width = clog2(WIDTH)+1.
- One sub-module, shift_add_multiplier:
  - Contains the operand shift registers, accumulator and counter.
  - Signals: load, step and done_mul.
- The FSM, read/write port driving and the add/overflow logic stay in mac_execute.

Test Plan:
- Basic op: regs r0=3, r1=4, r2=5; start with a=0, b=1, c=2, dst=6 at T → read_addr_A/B/C = 0/1/2 at T+1; write_enable=1, write_addr=6, write_data=17, overflow=0, done=1 at T+19 only.
- Overflow wrap: A=0xFFFF, B=0xFFFF, C=1 → write_data=0x0002, overflow=1.
- Overflow from the add stage only: A=1, B=1, C=0xFFFF → write_data=0x0000, overflow=1.
- Busy/ignore: pulse start again at T+5 with dst=7 → exactly one write (addr 6) at T+19; ready=0 over T+1..T+19; next start at T+20 accepted.
- Reset mid-MUL: RESET=1 at T+10 → ready=1, busy=0 at T+11; write_enable stays 0 through T+30; overflow=0.
- In-place update: r3=2; a=b=c=dst=3 → write_data=6 to addr 3; a follow-up identical command yields 42.
